// File: rtl/up_pkg.sv
// Shared encodings for the micro-processor control unit: states, opcodes, Asel codes.
package up_pkg;

  typedef enum logic [3:0] {
    ST_START    = 4'd0,
    ST_FETCH    = 4'd1,
    ST_DECODE   = 4'd2,
    ST_WAITSTEP = 4'd3,
    ST_LOAD     = 4'd8,
    ST_STORE    = 4'd9,
    ST_ADD      = 4'd10,
    ST_SUB      = 4'd11,
    ST_INPUT    = 4'd12,
    ST_JZ       = 4'd13,
    ST_JPOS     = 4'd14,
    ST_HALT     = 4'd15
  } state_e;

  localparam logic [2:0] OP_LOAD  = 3'b000;
  localparam logic [2:0] OP_STORE = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_INPUT = 3'b100;
  localparam logic [2:0] OP_JZ    = 3'b101;
  localparam logic [2:0] OP_JPOS  = 3'b110;
  localparam logic [2:0] OP_HALT  = 3'b111;

  localparam logic [1:0] ASEL_ALU = 2'b00;
  localparam logic [1:0] ASEL_IN  = 2'b01;
  localparam logic [1:0] ASEL_MEM = 2'b10;

  // Map an opcode to the execute state that implements it.
  function automatic state_e op_to_state(input logic [2:0] op);
    state_e s;
    case (op)
      OP_LOAD:  s = ST_LOAD;
      OP_STORE: s = ST_STORE;
      OP_ADD:   s = ST_ADD;
      OP_SUB:   s = ST_SUB;
      OP_INPUT: s = ST_INPUT;
      OP_JZ:    s = ST_JZ;
      OP_JPOS:  s = ST_JPOS;
      default:  s = ST_HALT;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/up_cu_if.sv
// Datapath <-> control unit signal bundle.
interface up_cu_if #(parameter int unsigned ICOUNT_W = 8);
  logic [2:0]          IR;
  logic                Aeq0;
  logic                Apos;
  logic                Enter;
  logic                StepMode;
  logic                Step;
  logic                IRload;
  logic                JMPmux;
  logic                PCload;
  logic                Meminst;
  logic                MemWr;
  logic                Aload;
  logic                Sub;
  logic [1:0]          Asel;
  logic                Halt;
  logic [3:0]          State;
  logic [ICOUNT_W-1:0] ICount;

  modport master (
    output IR, Aeq0, Apos, Enter, StepMode, Step,
    input  IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, Asel, Halt, State, ICount
  );

  modport slave (
    input  IR, Aeq0, Apos, Enter, StepMode, Step,
    output IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, Asel, Halt, State, ICount
  );
endinterface

// File: rtl/up_edge_det.sv
// Rising-edge detector: rise_c is high while d=1 and the registered copy is 0.
module up_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise_c
);
  logic prev_d, prev_q;

  // Next value of the delayed copy.
  always_comb prev_d = d;

  // Delayed copy of the input, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev_q <= 1'b0;
    else     prev_q <= prev_d;
  end

  assign rise_c = d & ~prev_q;
endmodule

// File: rtl/up_cu.sv
// Control unit FSM for the simple accumulator processor.
module up_cu
  import up_pkg::*;
#(
  parameter int unsigned ICOUNT_W = 8
) (
  input logic  CLOCK,
  input logic  RESET,
  up_cu_if.slave bus
);
  state_e              state_q, state_d, exec_next;
  logic [ICOUNT_W-1:0] icount_q, icount_d;
  logic                enter_rise, step_rise;
  logic                irload, jmpmux, pcload, meminst, memwr, aload, sub_op, halt;
  logic [1:0]          asel;

  up_edge_det u_enter_det (.clk(CLOCK), .rst(RESET), .d(bus.Enter), .rise_c(enter_rise));
  up_edge_det u_step_det  (.clk(CLOCK), .rst(RESET), .d(bus.Step),  .rise_c(step_rise));

  // Next-state, instruction counter and Moore/condition-qualified control decode.
  always_comb begin
    state_d   = state_q;
    icount_d  = icount_q;
    irload    = 1'b0;
    jmpmux    = 1'b0;
    pcload    = 1'b0;
    meminst   = 1'b0;
    memwr     = 1'b0;
    aload     = 1'b0;
    sub_op    = 1'b0;
    halt      = 1'b0;
    asel      = ASEL_ALU;
    exec_next = bus.StepMode ? ST_WAITSTEP : ST_FETCH;
    case (state_q)
      ST_START: state_d = ST_FETCH;
      ST_FETCH: begin
        irload   = 1'b1;
        pcload   = 1'b1;
        icount_d = icount_q + ICOUNT_W'(1);
        state_d  = ST_DECODE;
      end
      ST_DECODE: begin
        meminst = 1'b1;
        state_d = op_to_state(bus.IR);
      end
      ST_LOAD: begin
        meminst = 1'b1;
        asel    = ASEL_MEM;
        aload   = 1'b1;
        state_d = exec_next;
      end
      ST_STORE: begin
        meminst = 1'b1;
        memwr   = 1'b1;
        state_d = exec_next;
      end
      ST_ADD: begin
        meminst = 1'b1;
        aload   = 1'b1;
        state_d = exec_next;
      end
      ST_SUB: begin
        meminst = 1'b1;
        aload   = 1'b1;
        sub_op  = 1'b1;
        state_d = exec_next;
      end
      ST_INPUT: begin
        asel = ASEL_IN;
        // Only a fresh Enter press completes the instruction.
        if (enter_rise) begin
          aload   = 1'b1;
          state_d = exec_next;
        end
      end
      ST_JZ: begin
        jmpmux  = bus.Aeq0;
        pcload  = bus.Aeq0;
        state_d = exec_next;
      end
      ST_JPOS: begin
        jmpmux  = bus.Apos;
        pcload  = bus.Apos;
        state_d = exec_next;
      end
      ST_WAITSTEP: begin
        if (!bus.StepMode || step_rise) state_d = ST_FETCH;
      end
      ST_HALT: halt = 1'b1;
      default: state_d = ST_START;
    endcase
  end

  // State and instruction counter registers.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q  <= ST_START;
      icount_q <= '0;
    end else begin
      state_q  <= state_d;
      icount_q <= icount_d;
    end
  end

  assign bus.IRload  = irload;
  assign bus.JMPmux  = jmpmux;
  assign bus.PCload  = pcload;
  assign bus.Meminst = meminst;
  assign bus.MemWr   = memwr;
  assign bus.Aload   = aload;
  assign bus.Sub     = sub_op;
  assign bus.Asel    = asel;
  assign bus.Halt    = halt;
  assign bus.State   = 4'(state_q);
  assign bus.ICount  = icount_q;
endmodule

// File: tb/tb_up_cu.sv
// Scoreboard bench for up_cu: per-cycle expected state/controls/ICount.
module tb_up_cu;
  localparam int unsigned ICOUNT_W = 8;

  // Control vector: {IRload,JMPmux,PCload,Meminst,MemWr,Aload,Sub,Asel[1:0],Halt}
  localparam logic [9:0] C_0     = 10'b0_0_0_0_0_0_0_00_0;
  localparam logic [9:0] C_FETCH = 10'b1_0_1_0_0_0_0_00_0;
  localparam logic [9:0] C_DEC   = 10'b0_0_0_1_0_0_0_00_0;
  localparam logic [9:0] C_LOAD  = 10'b0_0_0_1_0_1_0_10_0;
  localparam logic [9:0] C_STORE = 10'b0_0_0_1_1_0_0_00_0;
  localparam logic [9:0] C_ADD   = 10'b0_0_0_1_0_1_0_00_0;
  localparam logic [9:0] C_SUB   = 10'b0_0_0_1_0_1_1_00_0;
  localparam logic [9:0] C_INW   = 10'b0_0_0_0_0_0_0_01_0;
  localparam logic [9:0] C_INL   = 10'b0_0_0_0_0_1_0_01_0;
  localparam logic [9:0] C_JMP   = 10'b0_1_1_0_0_0_0_00_0;
  localparam logic [9:0] C_HALT  = 10'b0_0_0_0_0_0_0_00_1;

  localparam logic [3:0] S_START = 4'd0, S_FETCH = 4'd1, S_DEC = 4'd2, S_WAIT = 4'd3;
  localparam logic [3:0] S_LOAD = 4'd8, S_STORE = 4'd9, S_ADD = 4'd10, S_SUB = 4'd11;
  localparam logic [3:0] S_IN = 4'd12, S_JZ = 4'd13, S_JPOS = 4'd14, S_HALT = 4'd15;

  typedef struct {
    string      tag;
    logic [3:0] st;
    logic [9:0] ctrl;
    logic [7:0] ic;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  up_cu_if #(.ICOUNT_W(ICOUNT_W)) bus ();

  up_cu #(.ICOUNT_W(ICOUNT_W)) dut (.CLOCK(clk), .RESET(rst), .bus(bus));

  always #5 clk = ~clk;

  exp_t       sb[$];
  int         n_total = 0;
  int         n_pass  = 0;
  logic [7:0] exp_ic  = 8'd0;
  logic [3:0] prev_st = 4'd0;

  // Pending inputs, applied just after the next rising edge.
  logic       n_rst = 1'b1;
  logic [2:0] n_ir = 3'd0;
  logic       n_enter = 1'b0, n_step = 1'b0, n_stepmode = 1'b0, n_aeq0 = 1'b0, n_apos = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  // Compare one cycle's outputs against the scoreboard head.
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      chk({e.tag, ".st"}, 32'(bus.State), 32'(e.st));
      chk({e.tag, ".ctl"}, 32'({bus.IRload, bus.JMPmux, bus.PCload, bus.Meminst, bus.MemWr,
                                bus.Aload, bus.Sub, bus.Asel, bus.Halt}), 32'(e.ctrl));
      chk({e.tag, ".ic"}, 32'(bus.ICount), 32'(e.ic));
    end
  end

  task automatic cyc(input string tag, input logic [3:0] st, input logic [9:0] ctrl);
    @(posedge clk);
    if (prev_st == S_FETCH) exp_ic = exp_ic + 8'd1;
    #2;
    rst          = n_rst;
    bus.IR       = n_ir;
    bus.Enter    = n_enter;
    bus.Step     = n_step;
    bus.StepMode = n_stepmode;
    bus.Aeq0     = n_aeq0;
    bus.Apos     = n_apos;
    if (n_rst) exp_ic = 8'd0;
    prev_st = n_rst ? S_START : st;
    sb.push_back('{tag, st, ctrl, exp_ic});
  endtask

  task automatic instr(input string tag, input logic [2:0] op, input logic [3:0] xs,
                       input logic [9:0] xc);
    n_ir = op;
    cyc({tag, ".f"}, S_FETCH, C_FETCH);
    cyc({tag, ".d"}, S_DEC, C_DEC);
    cyc({tag, ".x"}, xs, xc);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.IR = 3'd0; bus.Enter = 1'b0; bus.Step = 1'b0;
    bus.StepMode = 1'b0; bus.Aeq0 = 1'b0; bus.Apos = 1'b0;

    cyc("rst", S_START, C_0);
    n_rst = 1'b0;
    cyc("rel", S_START, C_0);

    instr("load", 3'b000, S_LOAD, C_LOAD);
    instr("store", 3'b001, S_STORE, C_STORE);
    instr("add", 3'b010, S_ADD, C_ADD);
    instr("sub", 3'b011, S_SUB, C_SUB);

    // INPUT waits for an Enter rising edge.
    n_enter = 1'b0;
    instr("in1", 3'b100, S_IN, C_INW);
    for (int i = 0; i < 4; i++) cyc("in1.w", S_IN, C_INW);
    n_enter = 1'b1;
    cyc("in1.e", S_IN, C_INL);
    // Held-high Enter must not complete a second INPUT.
    instr("in2", 3'b100, S_IN, C_INW);
    cyc("in2.w", S_IN, C_INW);
    cyc("in2.w", S_IN, C_INW);
    n_enter = 1'b0;
    cyc("in2.lo", S_IN, C_INW);
    n_enter = 1'b1;
    cyc("in2.e", S_IN, C_INL);
    n_enter = 1'b0;

    n_aeq0 = 1'b1;
    instr("jz1", 3'b101, S_JZ, C_JMP);
    n_aeq0 = 1'b0;
    instr("jz0", 3'b101, S_JZ, C_0);
    n_apos = 1'b1;
    instr("jp1", 3'b110, S_JPOS, C_JMP);
    n_apos = 1'b0;
    instr("jp0", 3'b110, S_JPOS, C_0);

    // Single-step: wait for Step edge, then leave via StepMode falling.
    n_stepmode = 1'b1;
    instr("st1", 3'b010, S_ADD, C_ADD);
    for (int i = 0; i < 3; i++) cyc("st1.w", S_WAIT, C_0);
    n_step = 1'b1;
    cyc("st1.s", S_WAIT, C_0);
    instr("st2", 3'b000, S_LOAD, C_LOAD);
    cyc("st2.w", S_WAIT, C_0);
    n_step = 1'b0;
    n_stepmode = 1'b0;
    cyc("st2.m", S_WAIT, C_0);

    // Enough instructions to wrap the 8-bit instruction counter.
    for (int i = 0; i < 260; i++) instr("wrap", 3'b010, S_ADD, C_ADD);

    instr("halt", 3'b111, S_HALT, C_HALT);
    for (int i = 0; i < 100; i++) cyc("halt.h", S_HALT, C_HALT);

    n_rst = 1'b1;
    cyc("r2", S_START, C_0);
    n_rst = 1'b0;
    cyc("r2.rel", S_START, C_0);
    n_ir = 3'b010;
    cyc("r2.f", S_FETCH, C_FETCH);
    // Asynchronous reset in the middle of DECODE.
    @(posedge clk);
    #2;
    chk("r2.dec", 32'(bus.State), 32'(S_DEC));
    #1 rst = 1'b1;
    #1;
    chk("r2.async.st", 32'(bus.State), 32'(S_START));
    chk("r2.async.ic", 32'(bus.ICount), 32'd0);
    chk("r2.async.ctl", 32'({bus.IRload, bus.JMPmux, bus.PCload, bus.Meminst, bus.MemWr,
                             bus.Aload, bus.Sub, bus.Asel, bus.Halt}), 32'(C_0));
    exp_ic = 8'd0;
    prev_st = S_START;
    n_rst = 1'b1;
    cyc("r3", S_START, C_0);
    n_rst = 1'b0;
    cyc("r3.rel", S_START, C_0);
    instr("r3.add", 3'b010, S_ADD, C_ADD);
    cyc("r3.nf", S_FETCH, C_FETCH);

    repeat (2) @(negedge clk);
    #1;
    chk("sb.drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
